// File: rtl/residual_pkg.sv
// Shared widths, Q-format and saturation helpers for the residual add/requant stage.
package residual_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ACC_WIDTH_DEF  = 20;
   localparam int Q_FRAC_BITS    = 7;

   function automatic int sat_max(input int width);
      return (1 << (width - 1)) - 1;
   endfunction

   function automatic int sat_min(input int width);
      return -(1 << (width - 1));
   endfunction

endpackage

// File: rtl/residual_add_requant_if.sv
// Conv, skip and result streams of the residual add/requant stage.
interface residual_add_requant_if
   import residual_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
   parameter int NUM_ELEMENTS = 16
);

   logic [NUM_ELEMENTS*ACC_WIDTH-1:0]  conv_data;
   logic                               conv_valid;
   logic                               conv_ready;
   logic [NUM_ELEMENTS*DATA_WIDTH-1:0] skip_data;
   logic                               skip_valid;
   logic                               skip_ready;
   logic [NUM_ELEMENTS*DATA_WIDTH-1:0] out_data;
   logic                               out_valid;
   logic                               out_ready;
   logic                               out_last;

   modport slave (
      input  conv_data, conv_valid, skip_data, skip_valid, out_ready,
      output conv_ready, skip_ready, out_data, out_valid, out_last
   );

   modport master (
      output conv_data, conv_valid, skip_data, skip_valid, out_ready,
      input  conv_ready, skip_ready, out_data, out_valid, out_last
   );

endinterface

// File: rtl/sat_round_shift.sv
// Per-element requant: round-half-up arithmetic right shift, then clamp to OUT_WIDTH signed bits.
module sat_round_shift
   import residual_pkg::*;
#(
   parameter int ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int OUT_WIDTH = DATA_WIDTH_DEF + 1,
   parameter int SHIFT     = Q_FRAC_BITS
) (
   input  logic signed [ACC_WIDTH-1:0] acc_i,
   output logic signed [OUT_WIDTH-1:0] r_o,
   output logic                        sat_o
);

   // One extra bit so adding the half-LSB never wraps.
   localparam logic signed [ACC_WIDTH:0] HALF =
      (SHIFT == 0) ? '0 : (ACC_WIDTH+1)'(2 ** ((SHIFT == 0) ? 0 : SHIFT - 1));
   localparam logic signed [ACC_WIDTH:0] R_MAX = (ACC_WIDTH+1)'(sat_max(OUT_WIDTH));
   localparam logic signed [ACC_WIDTH:0] R_MIN = (ACC_WIDTH+1)'(sat_min(OUT_WIDTH));

   function automatic logic signed [ACC_WIDTH:0] round_shift(input logic signed [ACC_WIDTH-1:0] a);
      logic signed [ACC_WIDTH:0] ext;
      ext = $signed({a[ACC_WIDTH-1], a});
      return (ext + HALF) >>> SHIFT;
   endfunction

   logic signed [ACC_WIDTH:0] rs;

   always_comb begin
      rs    = round_shift(acc_i);
      sat_o = 1'b0;
      r_o   = rs[OUT_WIDTH-1:0];
      if (rs > R_MAX) begin
         sat_o = 1'b1;
         r_o   = R_MAX[OUT_WIDTH-1:0];
      end else if (rs < R_MIN) begin
         sat_o = 1'b1;
         r_o   = R_MIN[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/residual_add_requant.sv
// Joins conv accumulators with the skip path: requant, add, saturate, frame beats into tensors.
module residual_add_requant
   import residual_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
   parameter int NUM_ELEMENTS = 16,
   parameter int SHIFT        = Q_FRAC_BITS,
   parameter int TENSOR_BEATS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   residual_add_requant_if.slave bus,
   input  logic                  sat_clear,
   output logic                  sat_flag
);

   localparam int RW    = DATA_WIDTH + 1;
   localparam int SUMW  = DATA_WIDTH + 2;
   localparam int CNT_W = (TENSOR_BEATS > 1) ? $clog2(TENSOR_BEATS) : 1;
   localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(TENSOR_BEATS - 1);
   localparam logic signed [SUMW-1:0] OUT_MAX  = SUMW'(sat_max(DATA_WIDTH));
   localparam logic signed [SUMW-1:0] OUT_MIN  = SUMW'(sat_min(DATA_WIDTH));

   function automatic logic signed [DATA_WIDTH-1:0] add_sat(
      input  logic signed [RW-1:0]         r,
      input  logic signed [DATA_WIDTH-1:0] skip,
      output logic                         sat
   );
      logic signed [SUMW-1:0] sum;
      sum = $signed({r[RW-1], r}) + $signed({{2{skip[DATA_WIDTH-1]}}, skip});
      sat = 1'b1;
      if (sum > OUT_MAX) return OUT_MAX[DATA_WIDTH-1:0];
      if (sum < OUT_MIN) return OUT_MIN[DATA_WIDTH-1:0];
      sat = 1'b0;
      return sum[DATA_WIDTH-1:0];
   endfunction

   logic                               s1_valid_q, s2_valid_q;
   logic                               s1_sat_q, s2_sat_q, sat_flag_q;
   logic signed [RW-1:0]               s1_r_q [NUM_ELEMENTS];
   logic [NUM_ELEMENTS*DATA_WIDTH-1:0] s1_skip_q, out_data_q, out_data_d;
   logic [CNT_W-1:0]                   cnt_q;
   logic signed [RW-1:0]               r_d [NUM_ELEMENTS];
   logic [NUM_ELEMENTS-1:0]            rq_sat, add_sat_vec;
   logic                               s1_adv, s2_adv, fire, out_hs;

   assign s2_adv = !s2_valid_q | bus.out_ready;
   assign s1_adv = !s1_valid_q | s2_adv;
   assign fire   = bus.conv_valid & bus.skip_valid & s1_adv;
   assign out_hs = s2_valid_q & bus.out_ready;

   assign bus.conv_ready = bus.skip_valid & s1_adv;
   assign bus.skip_ready = bus.conv_valid & s1_adv;
   assign bus.out_data   = out_data_q;
   assign bus.out_valid  = s2_valid_q;
   assign bus.out_last   = s2_valid_q & (cnt_q == LAST_CNT);
   assign sat_flag       = sat_flag_q;

   // Stage 1: requantize accumulators
   for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : g_rq
      sat_round_shift #(
         .ACC_WIDTH (ACC_WIDTH),
         .OUT_WIDTH (RW),
         .SHIFT     (SHIFT)
      ) u_rq (
         .acc_i (bus.conv_data[g*ACC_WIDTH +: ACC_WIDTH]),
         .r_o   (r_d[g]),
         .sat_o (rq_sat[g])
      );
   end

   always_ff @(posedge clk) begin
      if (fire) begin
         s1_r_q    <= r_d;
         s1_skip_q <= bus.skip_data;
         s1_sat_q  <= |rq_sat;
      end
   end

   // Stage 2: add skip and saturate to the output format
   always_comb begin
      out_data_d  = '0;
      add_sat_vec = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
         out_data_d[i*DATA_WIDTH +: DATA_WIDTH] =
            add_sat(s1_r_q[i], s1_skip_q[i*DATA_WIDTH +: DATA_WIDTH], add_sat_vec[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_sat_q   <= 1'b0;
         out_data_q <= '0;
         cnt_q      <= '0;
         sat_flag_q <= 1'b0;
      end else begin
         if (s1_adv) s1_valid_q <= fire;
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_data_q <= out_data_d;
               s2_sat_q   <= s1_sat_q | (|add_sat_vec);
            end
         end
         if (out_hs) cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
         // A saturating handshake outranks a coincident clear.
         if (out_hs && s2_sat_q) sat_flag_q <= 1'b1;
         else if (sat_clear)     sat_flag_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_residual_add_requant.sv
// Scoreboard bench for residual_add_requant with SHIFT=4, TENSOR_BEATS=4.
module tb_residual_add_requant;

   localparam int NE = 16;
   localparam int DW = 8;
   localparam int AW = 20;
   localparam int CW = NE * AW;
   localparam int SW = NE * DW;

   logic clk;
   logic rst_n;
   logic sat_clear;
   logic sat_flag;

   int total;
   int passed;
   logic [SW-1:0] exp_q [$];
   int out_cnt;
   int outs_seen;
   int lasts_seen;
   bit stall_prev;
   logic [SW-1:0] prev_data;

   residual_add_requant_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_ELEMENTS(NE)) bus ();

   residual_add_requant #(
      .DATA_WIDTH   (DW),
      .ACC_WIDTH    (AW),
      .NUM_ELEMENTS (NE),
      .SHIFT        (4),
      .TENSOR_BEATS (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .sat_clear (sat_clear),
      .sat_flag  (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [SW-1:0] model(input logic [CW-1:0] c, input logic [SW-1:0] s);
      logic [SW-1:0] res;
      int a, r, sk, sm;
      res = '0;
      for (int i = 0; i < NE; i++) begin
         a  = int'($signed(c[i*AW +: AW]));
         r  = int'($floor((real'(a) + 8.0) / 16.0));
         if (r > 255)  r = 255;
         if (r < -256) r = -256;
         sk = int'($signed(s[i*DW +: DW]));
         sm = r + sk;
         if (sm > 127)  sm = 127;
         if (sm < -128) sm = -128;
         res[i*DW +: DW] = sm[DW-1:0];
      end
      return res;
   endfunction

   function automatic logic [CW-1:0] fill_c(input int v);
      logic [CW-1:0] res;
      for (int i = 0; i < NE; i++) res[i*AW +: AW] = v[AW-1:0];
      return res;
   endfunction

   function automatic logic [SW-1:0] fill_s(input int v);
      logic [SW-1:0] res;
      for (int i = 0; i < NE; i++) res[i*DW +: DW] = v[DW-1:0];
      return res;
   endfunction

   // Scoreboard: push on accepted input beat, pop and compare on output handshake.
   always @(negedge clk) begin
      logic [SW-1:0] expd;
      logic exp_last;
      if (!rst_n) begin
         exp_q.delete();
         out_cnt    = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data)
               $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                        bus.out_valid, bus.out_data, prev_data);
            else passed++;
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            outs_seen++;
            if (bus.out_last === 1'b1) lasts_seen++;
            total++;
            exp_last = (out_cnt == 3);
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_beat: data=%h, required no beat", bus.out_data);
            end else begin
               expd = exp_q.pop_front();
               if (bus.out_data !== expd || bus.out_last !== exp_last)
                  $display("FAIL beat_data: data=%h last=%b, required data=%h last=%b",
                           bus.out_data, bus.out_last, expd, exp_last);
               else passed++;
            end
            out_cnt = (out_cnt + 1) % 4;
         end
         if (bus.conv_valid === 1'b1 && bus.skip_valid === 1'b1 &&
             bus.conv_ready === 1'b1 && bus.skip_ready === 1'b1)
            exp_q.push_back(model(bus.conv_data, bus.skip_data));
         stall_prev = (bus.out_valid === 1'b1 && bus.out_ready === 1'b0);
         prev_data  = bus.out_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      bus.conv_valid = 1'b0;
      bus.skip_valid = 1'b0;
      sat_clear      = 1'b0;
      rst_n          = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [CW-1:0] c, input logic [SW-1:0] s);
      int  n;
      bit  acc;
      n   = 0;
      acc = 1'b0;
      bus.conv_data  = c;
      bus.skip_data  = s;
      bus.conv_valid = 1'b1;
      bus.skip_valid = 1'b1;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = (bus.conv_ready === 1'b1) && (bus.skip_ready === 1'b1);
         step();
         n++;
      end
      bus.conv_valid = 1'b0;
      bus.skip_valid = 1'b0;
      total++;
      if (!acc) $display("FAIL send_accept: accepted=0 after %0d cycles, required accepted=1", n);
      else passed++;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && n < 200) begin
         step();
         n++;
      end
      total++;
      if (n >= 200) $display("FAIL drain: pending=%0d after %0d cycles, required 0", exp_q.size(), n);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      sat_clear      = 1'b0;
      bus.conv_valid = 1'b0;
      bus.skip_valid = 1'b0;
      bus.out_ready  = 1'b1;
      bus.conv_data  = '0;
      bus.skip_data  = '0;
      step();
      total++;
      if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0)
         $display("FAIL reset_ctrl: valid=%b last=%b, required 0 0", bus.out_valid, bus.out_last);
      else passed++;
      total++;
      if (bus.out_data !== '0) $display("FAIL reset_data: data=%h, required 0", bus.out_data);
      else passed++;
      total++;
      if (sat_flag !== 1'b0) $display("FAIL reset_sat: sat_flag=%b, required 0", sat_flag);
      else passed++;
      total++;
      if (bus.conv_ready !== 1'b0 || bus.skip_ready !== 1'b0)
         $display("FAIL reset_ready: conv_ready=%b skip_ready=%b, required 0 0",
                  bus.conv_ready, bus.skip_ready);
      else passed++;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      bus.out_ready = 1'b1;
      send(fill_c(400), fill_s(10));
      total++;
      if (bus.out_valid !== 1'b0) $display("FAIL latency_early: out_valid=%b, required 0", bus.out_valid);
      else passed++;
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== fill_s(35))
         $display("FAIL basic_35: valid=%b data=%h, required 1 %h", bus.out_valid, bus.out_data, fill_s(35));
      else passed++;
      wait_drain();
      total++;
      if (sat_flag !== 1'b0) $display("FAIL basic_sat: sat_flag=%b, required 0", sat_flag);
      else passed++;
   endtask

   task automatic test_rounding();
      logic [CW-1:0] c;
      logic [SW-1:0] e;
      int pat_a [4] = '{8, -8, -24, 7};
      int pat_e [4] = '{1, 0, -1, 0};
      for (int i = 0; i < NE; i++) begin
         c[i*AW +: AW] = pat_a[i%4][AW-1:0];
         e[i*DW +: DW] = pat_e[i%4][DW-1:0];
      end
      send(c, fill_s(0));
      step();
      total++;
      if (bus.out_data !== e) $display("FAIL round_half_up: data=%h, required %h", bus.out_data, e);
      else passed++;
      wait_drain();
   endtask

   task automatic test_saturation();
      int n;
      send(fill_c(4000), fill_s(100));
      send(fill_c(-4000), fill_s(-100));
      total++;
      if (bus.out_data !== fill_s(127)) $display("FAIL sat_pos: data=%h, required %h", bus.out_data, fill_s(127));
      else passed++;
      step();
      total++;
      if (bus.out_data !== fill_s(-128)) $display("FAIL sat_neg: data=%h, required %h", bus.out_data, fill_s(-128));
      else passed++;
      wait_drain();
      total++;
      if (sat_flag !== 1'b1) $display("FAIL sat_set: sat_flag=%b, required 1", sat_flag);
      else passed++;
      sat_clear = 1'b1;
      step();
      sat_clear = 1'b0;
      total++;
      if (sat_flag !== 1'b0) $display("FAIL sat_clear: sat_flag=%b, required 0", sat_flag);
      else passed++;
      bus.out_ready = 1'b0;
      send(fill_c(4000), fill_s(100));
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      bus.out_ready = 1'b1;
      sat_clear     = 1'b1;
      step();
      sat_clear = 1'b0;
      total++;
      if (sat_flag !== 1'b1) $display("FAIL sat_set_wins: sat_flag=%b, required 1", sat_flag);
      else passed++;
      wait_drain();
      sat_clear = 1'b1;
      step();
      sat_clear = 1'b0;
   endtask

   task automatic test_join();
      int base;
      base           = outs_seen;
      bus.out_ready  = 1'b1;
      bus.conv_data  = fill_c(160);
      bus.conv_valid = 1'b1;
      bus.skip_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (bus.conv_ready !== 1'b0 || bus.skip_ready !== 1'b1)
            $display("FAIL join_wait: conv_ready=%b skip_ready=%b, required 0 1",
                     bus.conv_ready, bus.skip_ready);
         else passed++;
         step();
      end
      send(fill_c(160), fill_s(-20));
      wait_drain();
      total++;
      if (outs_seen - base != 1) $display("FAIL join_single: outputs=%0d, required 1", outs_seen - base);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int base_o, base_l;
      bit done;
      logic [3:0] pat;
      apply_reset();
      base_o = outs_seen;
      base_l = lasts_seen;
      done   = 1'b0;
      pat    = 4'b1001;
      fork
         begin
            logic [CW-1:0] c;
            logic [SW-1:0] s;
            logic [31:0]   t;
            int            v;
            for (int b = 0; b < 8; b++) begin
               for (int i = 0; i < NE; i++) begin
                  t = $urandom;
                  v = int'($urandom_range(0, 8191)) - 4096;
                  c[i*AW +: AW] = (i % 2 == 0) ? v[AW-1:0] : t[AW-1:0];
                  s[i*DW +: DW] = t[31:24];
               end
               send(c, s);
            end
            done = 1'b1;
         end
         begin
            int k;
            k = 0;
            while (!(done && exp_q.size() == 0 && bus.out_valid !== 1'b1) && k < 300) begin
               bus.out_ready = pat[k%4];
               step();
               k++;
            end
            bus.out_ready = 1'b1;
         end
      join
      total++;
      if (outs_seen - base_o != 8) $display("FAIL b2b_count: outputs=%0d, required 8", outs_seen - base_o);
      else passed++;
      total++;
      if (lasts_seen - base_l != 2) $display("FAIL b2b_last: lasts=%0d, required 2", lasts_seen - base_l);
      else passed++;
   endtask

   task automatic test_reset_midflight();
      int base_o, base_l;
      bus.out_ready = 1'b0;
      send(fill_c(400), fill_s(1));
      send(fill_c(800), fill_s(2));
      total++;
      if (bus.out_valid !== 1'b1) $display("FAIL midflight_full: out_valid=%b, required 1", bus.out_valid);
      else passed++;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0)
         $display("FAIL reset_async: valid=%b last=%b, required 0 0", bus.out_valid, bus.out_last);
      else passed++;
      step();
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      base_o = outs_seen;
      base_l = lasts_seen;
      for (int b = 0; b < 4; b++) send(fill_c(16 * b), fill_s(b));
      wait_drain();
      total++;
      if (outs_seen - base_o != 4 || lasts_seen - base_l != 1)
         $display("FAIL post_reset: outputs=%0d lasts=%0d, required 4 1",
                  outs_seen - base_o, lasts_seen - base_l);
      else passed++;
   endtask

   initial begin
      total      = 0;
      passed     = 0;
      outs_seen  = 0;
      lasts_seen = 0;
      out_cnt    = 0;
      stall_prev = 1'b0;
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_join();
      test_back_to_back();
      test_reset_midflight();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time=%0t, required completion before 500000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/residual_add_requant.md
Name: residual_add_requant

Overview:
- Streaming stage directly upstream of the leaky ReLU array in the residual block.
- Joins the conv accumulator stream (wide, ACC_WIDTH per element) with the skip-path stream (Q1.7, DATA_WIDTH per element).
- Requantizes the accumulators by a rounding arithmetic right shift, adds the skip tensor, saturates to DATA_WIDTH, and emits a packed tensor beat.
- 2-stage valid/ready pipeline with beat framing and a sticky saturation flag.

Parameters:
- DATA_WIDTH, 8, element width of skip and output (signed Q1.7)
- ACC_WIDTH, 20, element width of conv accumulator input (signed)
- NUM_ELEMENTS, 16, elements per beat
- SHIFT, 7, requant right-shift amount, 0..ACC_WIDTH-2
- TENSOR_BEATS, 4, beats per tensor; out_last framing period, >=1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- conv_data  in  NUM_ELEMENTS*ACC_WIDTH  packed accumulators, element i at [i*ACC_WIDTH +: ACC_WIDTH]
- conv_valid  in  1  conv beat valid
- conv_ready  out  1  conv beat accepted when high with conv_valid
- skip_data  in  NUM_ELEMENTS*DATA_WIDTH  packed skip elements
- skip_valid  in  1  skip beat valid
- skip_ready  out  1  skip beat accepted when high with skip_valid
- out_data  out  NUM_ELEMENTS*DATA_WIDTH  packed result; feeds leaky ReLU in_tensor
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_last  out  1  high on final beat (index TENSOR_BEATS-1) of each tensor
- sat_flag  out  1  sticky: any element saturated since last clear
- sat_clear  in  1  synchronous clear of sat_flag

Behaviour:
- Reset (async assert, sync-safe deassert via flops): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_last=0, sat_flag=0, beat counter=0. Reset mid-operation discards all in-flight beats.
- Join: fire = conv_valid & skip_valid & s1_adv, where s1_adv = !s1_valid | s2_adv and s2_adv = !s2_valid | out_ready.
  - conv_ready = skip_valid & s1_adv; skip_ready = conv_valid & s1_adv. Neither ready depends on its own valid.
  - Both inputs are consumed in the same cycle only; a lone valid waits without being consumed.
- Stage 1 (requant), per element:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT, computed in ACC_WIDTH+1 bits. For SHIFT=0, r = acc.
  - Rounding is half toward +inf.
  - r is clamped to DATA_WIDTH+1 signed bits (-256..255) and registered.
  - If the clamp activates, s1_sat is set for the beat.
  - Skip elements are registered alongside.
- Stage 2 (add), per element:
  - sum = r + sign-extended skip, DATA_WIDTH+2 bits.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] (-128..127 at default).
  - Register into out_data; s2_sat = s1_sat | any stage-2 clamp.
- Latency: 2 cycles from fire to out_valid when unstalled; throughput 1 beat/cycle.
- Stall: when out_valid & !out_ready, out_data, out_last and out_valid hold stable; stage 1 holds if full; inputs are not accepted.
- Beat counter:
  - Increments on out handshake (out_valid & out_ready).
  - Wraps to 0 after TENSOR_BEATS-1.
  - out_last = out_valid & (count == TENSOR_BEATS-1). For TENSOR_BEATS=1, out_last equals out_valid.
- sat_flag:
  - Set on the out handshake of a beat with s2_sat.
  - Cleared by sat_clear; if set and clear occur in the same cycle, set wins.

Decomposition:
- Shared package (residual_pkg): DATA_WIDTH/ACC_WIDTH defaults, Q-format fraction bits (7), and saturation min/max constants derived from DATA_WIDTH.
- One sub-module: sat_round_shift. Pure combinational per-element rounding shift plus clamp, with a sat output, instantiated NUM_ELEMENTS times in stage 1.
- The stage-2 add/saturate stays inline.

Test Plan:
- SHIFT=4, all elements acc=400, skip=10, out_ready=1 -> 2 cycles later out elements=35, sat_flag=0.
- SHIFT=4, acc={8,-8,-24,7}, skip=0 -> {1,0,-1,0}, confirming round-half-up.
- SHIFT=4, acc=4000, skip=100 -> 127; acc=-4000, skip=-100 -> -128; sat_flag=1 after handshake. sat_clear with no saturating beat -> 0. Clear coincident with a saturating beat -> flag stays 1.
- conv_valid held 3 cycles with skip_valid=0 -> conv_ready=0, no beat consumed. Skip arrives -> single fire, single output.
- 8 back-to-back beats, out_ready toggled 1,0,0,1,... -> no loss or duplication, data stable while stalled, out_last on beats 3 and 7 (TENSOR_BEATS=4).
- rst_n asserted with 2 beats in flight -> out_valid=0 immediately. After release, next beat gets out_last only at count 3 from zero.
